// File: rtl/arith_enc_pkg.sv
// Shared constants for the AV1 arithmetic encoder datapath: default widths
// of the range/low registers, the range pre-shift, and the derivation of the
// renormalisation shift-count width.
package arith_enc_pkg;

  localparam int DEF_RANGE_WIDTH = 16;
  localparam int DEF_LOW_WIDTH   = 24;
  localparam int DEF_RR_SHIFT    = 8;

  // A shift count must be able to express every value 0..range_width
  // (range_width itself means "range collapsed to zero").
  function automatic int d_width(input int range_width);
    return $clog2(range_width + 1);
  endfunction

  localparam int DEF_D_WIDTH = d_width(DEF_RANGE_WIDTH);

endpackage

// File: rtl/lzc_count.sv
// Combinational leading-zero counter. An all-zero input reports WIDTH so the
// caller can tell "no set bit" apart from "MSB clear, next bit set".
module lzc_count
  import arith_enc_pkg::*;
#(
  parameter int WIDTH = DEF_RANGE_WIDTH,
  localparam int CW   = d_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count
);

  // Scan from LSB upward; the highest set bit is visited last and wins.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) begin
        count = CW'(WIDTH - 1 - i);
      end else begin
        count = count;
      end
    end
  end

endmodule

// File: rtl/stage_2_pipe.sv
// Range/low update stage of the AV1 arithmetic encoder.
// Stage 1 forms the three RR-scaled probability products; stage 2 applies the
// symbol update, renormalises range to an MSB-set value and shifts low by the
// same amount, exposing the bits pushed out of low as out_spill.
// Two-entry valid/ready pipeline: each stage holds one token.
module stage_2_pipe
  import arith_enc_pkg::*;
#(
  parameter int RANGE_WIDTH = DEF_RANGE_WIDTH,
  parameter int LOW_WIDTH   = DEF_LOW_WIDTH,
  parameter int RR_SHIFT    = DEF_RR_SHIFT,
  localparam int D_WIDTH    = d_width(RANGE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_comp,
  input  logic [RANGE_WIDTH-1:0] in_uu,
  input  logic [RANGE_WIDTH-1:0] in_vv,
  input  logic [RANGE_WIDTH-1:0] in_a,
  input  logic [RANGE_WIDTH-1:0] in_range,
  input  logic [LOW_WIDTH-1:0]   in_low,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RANGE_WIDTH-1:0] out_range,
  output logic [LOW_WIDTH-1:0]   out_low,
  output logic [RANGE_WIDTH-1:0] out_spill,
  output logic [D_WIDTH-1:0]     out_shift,
  output logic                   err_zero_range
);

  localparam int WIDE = RANGE_WIDTH + LOW_WIDTH;

  // Stage 1 state
  logic                   s1_valid;
  logic                   s1_comp;
  logic [RANGE_WIDTH-1:0] s1_range;
  logic [LOW_WIDTH-1:0]   s1_low;
  logic [RANGE_WIDTH-1:0] s1_pu;
  logic [RANGE_WIDTH-1:0] s1_pa;
  logic [RANGE_WIDTH-1:0] s1_pv;

  // Flow control
  logic s2_advance;

  // Stage 1 products (truncated to RANGE_WIDTH by the assignment context)
  logic [RANGE_WIDTH-1:0] rr;
  logic [RANGE_WIDTH-1:0] mul_u;
  logic [RANGE_WIDTH-1:0] mul_a;
  logic [RANGE_WIDTH-1:0] mul_v;

  // Stage 2 update and renormalisation
  logic [LOW_WIDTH-1:0]   low_n;
  logic [RANGE_WIDTH-1:0] range_n;
  logic [D_WIDTH-1:0]     shift_n;
  logic [RANGE_WIDTH-1:0] norm_range;
  logic [WIDE-1:0]        norm_wide;

  // Handshake: output register frees when empty or being taken; stage 1 moves
  // exactly when stage 2 can load. in_ready has no dependence on in_valid.
  always_comb begin
    s2_advance = !out_valid || out_ready;
    in_ready   = !s1_valid || s2_advance;
  end

  // Scale the three probability terms by the pre-shifted range.
  always_comb begin
    rr    = in_range >> RR_SHIFT;
    mul_u = rr * in_uu;
    mul_a = rr * in_a;
    mul_v = rr * in_vv;
  end

  // Stage 1 register: capture a new token, or empty once its token moves on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_comp  <= 1'b0;
      s1_range <= '0;
      s1_low   <= '0;
      s1_pu    <= '0;
      s1_pa    <= '0;
      s1_pv    <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_comp  <= in_comp;
      s1_range <= in_range;
      s1_low   <= in_low;
      s1_pu    <= mul_u;
      s1_pa    <= mul_a;
      s1_pv    <= mul_v;
    end else if (s2_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Symbol update on low/range, modulo the respective register widths.
  always_comb begin
    if (s1_comp) begin
      low_n   = s1_low + LOW_WIDTH'(s1_range) - LOW_WIDTH'(s1_pu);
      range_n = s1_pa;
    end else begin
      low_n   = s1_low;
      range_n = s1_range - s1_pv;
    end
  end

  lzc_count #(
    .WIDTH (RANGE_WIDTH)
  ) u_lzc (
    .data  (range_n),
    .count (shift_n)
  );

  // Renormalise: low shifts together with range; the overflow lands in spill.
  always_comb begin
    norm_range = range_n << shift_n;
    norm_wide  = {{RANGE_WIDTH{1'b0}}, low_n} << shift_n;
  end

  // Output register: hold while stalled, otherwise load from stage 1; the
  // zero-range flag is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_range      <= '0;
      out_low        <= '0;
      out_spill      <= '0;
      out_shift      <= '0;
      err_zero_range <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_range <= norm_range;
        out_low   <= norm_wide[LOW_WIDTH-1:0];
        out_spill <= norm_wide[LOW_WIDTH +: RANGE_WIDTH];
        out_shift <= shift_n;
        if (range_n == '0) begin
          err_zero_range <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stage_2_pipe.sv
// Scoreboard bench for stage_2_pipe: the driver pushes hand-computed results
// as tokens are accepted, a monitor pops and compares on every output handshake.
module tb_stage_2_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_comp;
  logic [15:0] in_uu;
  logic [15:0] in_vv;
  logic [15:0] in_a;
  logic [15:0] in_range;
  logic [23:0] in_low;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_range;
  logic [23:0] out_low;
  logic [15:0] out_spill;
  logic [4:0]  out_shift;
  logic        err_zero_range;

  stage_2_pipe dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_comp        (in_comp),
    .in_uu          (in_uu),
    .in_vv          (in_vv),
    .in_a           (in_a),
    .in_range       (in_range),
    .in_low         (in_low),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_range      (out_range),
    .out_low        (out_low),
    .out_spill      (out_spill),
    .out_shift      (out_shift),
    .err_zero_range (err_zero_range)
  );

  typedef struct {
    logic [15:0] range;
    logic [23:0] low;
    logic [15:0] spill;
    logic [4:0]  shift;
    int          lat;   // expected cycle of first appearance, -1 = don't care
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on each output handshake; also require a stalled payload
  // to stay put until it is taken.
  logic        held = 1'b0;
  logic [15:0] h_range;
  logic [23:0] h_low;
  logic [15:0] h_spill;
  logic [4:0]  h_shift;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held && out_valid) begin
        chk("stall_range", out_range, h_range);
        chk("stall_low",   out_low,   h_low);
        chk("stall_spill", out_spill, h_spill);
        chk("stall_shift", out_shift, h_shift);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("out_range", out_range, e.range);
          chk("out_low",   out_low,   e.low);
          chk("out_spill", out_spill, e.spill);
          chk("out_shift", out_shift, e.shift);
          if (e.lat >= 0) chk("latency", cyc, e.lat);
        end
      end
      held    = out_valid && !out_ready;
      h_range = out_range;
      h_low   = out_low;
      h_spill = out_spill;
      h_shift = out_shift;
    end
  end

  // Drive one token and wait (bounded) for acceptance; expectation is queued
  // at the negedge where acceptance is certain.
  task automatic send(input logic comp, input logic [15:0] rng, input logic [23:0] low,
                      input logic [15:0] uu, input logic [15:0] vv, input logic [15:0] a,
                      input logic [15:0] e_rng, input logic [23:0] e_low,
                      input logic [15:0] e_spill, input logic [4:0] e_shift,
                      input logic lat_chk);
    exp_t e;
    bit   done = 1'b0;
    in_valid = 1'b1;
    in_comp  = comp;
    in_range = rng;
    in_low   = low;
    in_uu    = uu;
    in_vv    = vv;
    in_a     = a;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.range = e_rng;
        e.low   = e_low;
        e.spill = e_spill;
        e.shift = e_shift;
        e.lat   = lat_chk ? cyc + 2 : -1;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_comp   = 1'b0;
    in_uu     = 16'h0;
    in_vv     = 16'h0;
    in_a      = 16'h0;
    in_range  = 16'h0;
    in_low    = 24'h0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err",       err_zero_range, 1'b0);
    chk("rst_in_ready",  in_ready, 1'b1);
    chk("rst_out_range", out_range, 16'h0);
    chk("rst_out_low",   out_low, 24'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // T1: comp=1 update
    send(1'b1, 16'h8000, 24'h000100, 16'h0040, 16'h0000, 16'h0020,
         16'h8000, 24'h030800, 16'h0000, 5'd3, 1'b1);
    drain();
    chk("t1_err_clear", err_zero_range, 1'b0);

    // T2: range collapses to zero, full 16-bit shift into spill
    send(1'b0, 16'hC000, 24'h123456, 16'h0000, 16'h0100, 16'h0000,
         16'h0000, 24'h560000, 16'h1234, 5'd16, 1'b1);
    drain();
    chk("t2_err_set", err_zero_range, 1'b1);

    // T3: no renormalisation needed
    send(1'b0, 16'hFF00, 24'h000ABC, 16'h0000, 16'h0001, 16'h0000,
         16'hFE01, 24'h000ABC, 16'h0000, 5'd0, 1'b1);
    drain();
    chk("t3_err_sticky", err_zero_range, 1'b1);

    // T4: 8 back-to-back tokens, each shifted by one
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 16'h4000 + 16'(i), 24'h010000 + 24'(i), 16'h0, 16'h0, 16'h0,
           16'h8000 + 16'(2 * i), 24'h020000 + 24'(2 * i), 16'h0000, 5'd1, 1'b1);
    end
    drain();

    // T5: 4 tokens against a 3-cycle downstream stall
    out_ready = 1'b0;
    send(1'b0, 16'h2000, 24'h800000, 16'h0, 16'h0, 16'h0,
         16'h8000, 24'h000000, 16'h0002, 5'd2, 1'b0);
    send(1'b0, 16'h2001, 24'h800001, 16'h0, 16'h0, 16'h0,
         16'h8004, 24'h000004, 16'h0002, 5'd2, 1'b0);
    fork
      begin
        send(1'b0, 16'h2002, 24'h800002, 16'h0, 16'h0, 16'h0,
             16'h8008, 24'h000008, 16'h0002, 5'd2, 1'b0);
        send(1'b0, 16'h2003, 24'h800003, 16'h0, 16'h0, 16'h0,
             16'h800C, 24'h00000C, 16'h0002, 5'd2, 1'b0);
      end
      begin
        for (int n = 0; n < 3; n++) begin
          @(negedge clk);
          chk("t5_in_ready_low", in_ready, 1'b0);
          chk("t5_out_valid",    out_valid, 1'b1);
          @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // T6: reset with two tokens in flight
    out_ready = 1'b0;
    send(1'b1, 16'h8000, 24'h000100, 16'h0040, 16'h0000, 16'h0020,
         16'h8000, 24'h030800, 16'h0000, 5'd3, 1'b0);
    send(1'b0, 16'hFF00, 24'h000ABC, 16'h0000, 16'h0001, 16'h0000,
         16'hFE01, 24'h000ABC, 16'h0000, 5'd0, 1'b0);
    chk("t6_pre_err", err_zero_range, 1'b1);
    chk("t6_pre_valid", out_valid, 1'b1);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_err", err_zero_range, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    send(1'b0, 16'hFF00, 24'h000ABC, 16'h0000, 16'h0001, 16'h0000,
         16'hFE01, 24'h000ABC, 16'h0000, 5'd0, 1'b1);
    drain();
    chk("t6_err_after", err_zero_range, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_out_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
